mem_wb_stage: RTL and testbench



---
 rtl/mem_wb_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_wb_stage.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// mem_wb_stage: MEM->WB pipeline stage. Runs one data-memory request at a time
// with byte-lane steering, flush/kill handling and a sticky response timeout.
// Revision: 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int REG_W     = 3,
  parameter int CTRL_W    = 32,
  parameter bit SEXT_BYTE = 1'b1,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [REG_W-1:0]  in_dest,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [REG_W-1:0]  out_dest,
  output logic [DATA_W-1:0] out_alu,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W/8-1:0] mem_byte_en,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  localparam int c_NBYTES = DATA_W / 8;
  localparam int c_LANE_W = $clog2(c_NBYTES);
  localparam int c_CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_MAX = c_CNT_W'(TIMEOUT);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_NBYTES-1:0] c_LANE0   = {{(c_NBYTES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_kill;
  logic                 r_load;
  logic                 r_byte;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_accept;
  logic                 w_is_mem;
  logic [c_LANE_W-1:0]  w_in_lane;
  logic [c_NBYTES-1:0]  w_in_be;
  logic [DATA_W-1:0]    w_in_wdata;
  logic [c_LANE_W-1:0]  w_rd_lane;
  logic [DATA_W-1:0]    w_rd_shift;
  logic [7:0]           w_rd_byte;
  logic [DATA_W-1:0]    w_load_data;
  logic [c_CNT_W-1:0]   w_cnt_inc;

  assign in_ready  = !flush && ((r_state == S_EMPTY) || ((r_state == S_FULL) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign w_is_mem  = in_mem_read || in_mem_write;
  assign out_valid = (r_state == S_FULL);

  // Byte stores replicate the low byte so any lane can pick it up.
  assign w_in_lane  = in_alu[c_LANE_W-1:0];
  assign w_in_be    = in_byte ? (c_LANE0 << w_in_lane) : {c_NBYTES{1'b1}};
  assign w_in_wdata = in_byte ? {c_NBYTES{in_wdata[7:0]}} : in_wdata;

  assign w_rd_lane   = mem_addr[c_LANE_W-1:0];
  assign w_rd_shift  = mem_rdata >> {w_rd_lane, 3'b000};
  assign w_rd_byte   = w_rd_shift[7:0];
  assign w_load_data = r_byte ? {{(DATA_W-8){SEXT_BYTE && w_rd_byte[7]}}, w_rd_byte} : mem_rdata;
  assign w_cnt_inc   = r_cnt + c_CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_kill      <= 1'b0;
      r_load      <= 1'b0;
      r_byte      <= 1'b0;
      r_cnt       <= '0;
      out_pc      <= '0;
      out_dest    <= '0;
      out_alu     <= '0;
      out_ctrl    <= '0;
      out_rdata   <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_byte_en <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_BUSY: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            r_kill    <= 1'b0;
            // A killed instruction completes its bus cycle but never reaches writeback.
            if (r_kill || flush) begin
              r_state <= S_EMPTY;
            end else begin
              r_state <= S_FULL;
              if (r_load) begin
                out_rdata <= w_load_data;
              end
            end
          end else begin
            if (flush) begin
              r_kill <= 1'b1;
            end
            if ((TIMEOUT != 0) && (r_cnt != c_CNT_MAX)) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == c_CNT_MAX) begin
                timeout_err <= 1'b1;
              end
            end
          end
        end
        default: begin
          if (flush) begin
            r_state <= S_EMPTY;
          end else if (w_accept) begin
            out_pc    <= in_pc;
            out_dest  <= in_dest;
            out_alu   <= in_alu;
            out_ctrl  <= in_ctrl;
            out_rdata <= '0;
            if (w_is_mem) begin
              r_state     <= S_BUSY;
              mem_write   <= in_mem_write;
              mem_read    <= !in_mem_write;
              mem_addr    <= ADDR_W'(in_alu);
              mem_wdata   <= w_in_wdata;
              mem_byte_en <= w_in_be;
              r_load      <= !in_mem_write;
              r_byte      <= in_byte;
              r_cnt       <= '0;
              r_kill      <= 1'b0;
            end else begin
              r_state <= S_FULL;
            end
          end else if ((r_state == S_FULL) && out_ready) begin
            r_state <= S_EMPTY;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage with a byte-array memory
// model, random traffic and directed backpressure/flush/timeout scenarios.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  localparam bit SEXT = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_pc = '0;
  logic [2:0]  in_dest = '0;
  logic [15:0] in_alu = '0;
  logic [15:0] in_wdata = '0;
  logic [31:0] in_ctrl = '0;
  logic        in_mem_read = 1'b0;
  logic        in_mem_write = 1'b0;
  logic        in_byte = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [2:0]  out_dest;
  logic [15:0] out_alu;
  logic [31:0] out_ctrl;
  logic [15:0] out_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_en;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        timeout_err;

  mem_wb_stage #(
    .DATA_W(16), .ADDR_W(16), .REG_W(3), .CTRL_W(32), .SEXT_BYTE(SEXT), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_dest(in_dest),
    .in_alu(in_alu), .in_wdata(in_wdata), .in_ctrl(in_ctrl),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_byte(in_byte),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_dest(out_dest),
    .out_alu(out_alu), .out_ctrl(out_ctrl), .out_rdata(out_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [2:0]  dest;
    logic [15:0] alu;
    logic [15:0] wdata;
    logic [31:0] ctrl;
    logic        rd;
    logic        wr;
    logic        byt;
  } op_t;

  typedef struct {
    logic [15:0] pc;
    logic [2:0]  dest;
    logic [15:0] alu;
    logic [31:0] ctrl;
    logic [15:0] rdata;
  } res_t;

  typedef struct {
    logic [15:0] addr;
    logic        write;
    logic        byt;
    logic [15:0] wdata;
    logic [1:0]  be;
  } bus_t;

  res_t exp_q[$];
  bus_t bus_q[$];
  logic [7:0] ref_mem [0:63];
  logic [7:0] bus_mem [0:63];

  int n_checks = 0;
  int n_errors = 0;
  bit ready_rand = 1'b0;
  bit ready_force = 1'b1;
  bit mem_stall = 1'b0;
  int fixed_delay = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte-addressed little-endian memory, one transaction at a time in issue order.
  task automatic model_push(input op_t o);
    res_t r;
    bus_t b;
    int   a;
    logic [7:0] v;
    a = int'(o.alu[5:0]);
    r.pc = o.pc; r.dest = o.dest; r.alu = o.alu; r.ctrl = o.ctrl; r.rdata = 16'h0000;
    b.addr = o.alu; b.byt = o.byt; b.wdata = 16'h0000;
    b.be = o.byt ? (o.alu[0] ? 2'b10 : 2'b01) : 2'b11;
    if (o.wr) begin
      b.write = 1'b1;
      if (o.byt) begin
        ref_mem[a] = o.wdata[7:0];
        b.wdata = {o.wdata[7:0], o.wdata[7:0]};
      end else begin
        ref_mem[a]     = o.wdata[7:0];
        ref_mem[a + 1] = o.wdata[15:8];
        b.wdata = o.wdata;
      end
      bus_q.push_back(b);
    end else if (o.rd) begin
      b.write = 1'b0;
      if (o.byt) begin
        v = ref_mem[a];
        r.rdata = (SEXT && v[7]) ? {8'hFF, v} : {8'h00, v};
      end else begin
        r.rdata = {ref_mem[a + 1], ref_mem[a]};
      end
      bus_q.push_back(b);
    end
    exp_q.push_back(r);
  endtask

  function automatic op_t mk(input logic [15:0] alu, input logic [15:0] wdata,
                             input logic rd, input logic wr, input logic byt);
    op_t o;
    o.pc = 16'($urandom); o.dest = 3'($urandom); o.ctrl = $urandom;
    o.alu = alu; o.wdata = wdata; o.rd = rd; o.wr = wr; o.byt = byt;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  t;
    t = int'($urandom_range(0, 9));
    o = mk(16'($urandom), 16'($urandom), (t >= 4 && t <= 6) || t == 9, t >= 7,
           1'($urandom_range(0, 1)));
    if (o.rd || o.wr) begin
      o.alu = o.byt ? 16'h3000 + 16'($urandom_range(0, 63))
                    : 16'h3000 + 16'(2 * $urandom_range(0, 31));
    end
    return o;
  endfunction

  task automatic drive(input op_t o);
    in_pc = o.pc; in_dest = o.dest; in_alu = o.alu; in_wdata = o.wdata; in_ctrl = o.ctrl;
    in_mem_read = o.rd; in_mem_write = o.wr; in_byte = o.byt;
    in_valid = 1'b1;
  endtask

  task automatic handshake(input op_t o);
    int b;
    b = 0;
    @(negedge clk);
    while (!in_ready && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("accept_wait", in_ready, 1'b1);
    if (in_ready) model_push(o);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || out_valid || mem_read || mem_write) && b < 300) begin
      @(negedge clk);
      b++;
    end
    chk("drain_queue", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = ready_rand ? ($urandom_range(0, 9) < 7) : ready_force;
    end
  end

  // Memory responder: checks each request against the model, then answers after a delay.
  initial begin
    bus_t e;
    bit   aborted;
    int   d;
    int   base;
    mem_resp = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_n && (mem_read || mem_write)) begin
        aborted = 1'b0;
        if (bus_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL bus_unexpected: got addr 0x%0h expected no request", mem_addr);
        end else begin
          e = bus_q.pop_front();
          chk("bus_addr", mem_addr, e.addr);
          chk("bus_write", mem_write, e.write);
          chk("bus_read", mem_read, !e.write);
          if (e.write) chk("bus_wdata", mem_wdata, e.wdata);
          if (e.write || !e.byt) chk("bus_byte_en", mem_byte_en, e.be);
        end
        d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
        repeat (d) @(negedge clk);
        while (mem_stall && !aborted) begin
          @(negedge clk);
          if (!(mem_read || mem_write)) aborted = 1'b1;
        end
        if (!aborted) begin
          base = int'({mem_addr[5:1], 1'b0});
          if (mem_write) begin
            for (int i = 0; i < 2; i++)
              if (mem_byte_en[i]) bus_mem[base + i] = mem_wdata[i*8 +: 8];
          end else begin
            mem_rdata = {bus_mem[base + 1], bus_mem[base]};
          end
          mem_resp = 1'b1;
          @(negedge clk);
          mem_resp = 1'b0;
          mem_rdata = 16'($urandom);
        end
      end
    end
  end

  // Monitor: every result taken by writeback must match the oldest expectation.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL out_unexpected: got alu 0x%0h expected no result", out_alu);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_dest", out_dest, e.dest);
          chk("out_alu", out_alu, e.alu);
          chk("out_ctrl", out_ctrl, e.ctrl);
          chk("out_rdata", out_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    op_t ox;
    op_t oy;
    logic [7:0] v;
    int b;
    for (int i = 0; i < 64; i++) begin
      v = 8'($urandom);
      ref_mem[i] = v;
      bus_mem[i] = v;
    end

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_strobes", {mem_read, mem_write}, 2'b00);
    chk("rst_byte_en", mem_byte_en, 2'b00);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_rdata", out_rdata, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    ready_rand = 1'b1;
    for (int n = 0; n < 80; n++) begin
      o = rand_op();
      drive(o);
      handshake(o);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    ready_rand = 1'b0;
    ready_force = 1'b1;
    wait_drain();
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back non-memory ops.
    for (int i = 1; i <= 4; i++) begin
      o = mk(16'(i), 16'h0000, 1'b0, 1'b0, 1'b0);
      drive(o);
      @(negedge clk);
      chk("burst_in_ready", in_ready, 1'b1);
      if (i > 1) begin
        chk("burst_valid", out_valid, 1'b1);
        chk("burst_alu", out_alu, 16'(i - 1));
      end
      model_push(o);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("burst_last_valid", out_valid, 1'b1);
    chk("burst_last_alu", out_alu, 16'h0004);
    wait_drain();

    // Word store then word load with a 3-cycle response.
    o = mk(16'h3000, 16'hBEEF, 1'b0, 1'b1, 1'b0);
    drive(o); handshake(o); in_valid = 1'b0;
    wait_drain();
    fixed_delay = 2;
    o = mk(16'h3000, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(o); handshake(o); in_valid = 1'b0;
    @(negedge clk);
    chk("wl_rd_c1", mem_read, 1'b1);
    chk("wl_byte_en", mem_byte_en, 2'b11);
    chk("wl_addr", mem_addr, 16'h3000);
    @(negedge clk);
    chk("wl_rd_c2", mem_read, 1'b1);
    @(negedge clk);
    chk("wl_rd_c3", mem_read, 1'b1);
    @(negedge clk);
    chk("wl_rd_done", mem_read, 1'b0);
    chk("wl_valid", out_valid, 1'b1);
    chk("wl_rdata", out_rdata, 16'hBEEF);
    fixed_delay = -1;
    wait_drain();

    // Sign-extended byte load from the high lane, then a byte store.
    o = mk(16'h3000, 16'h80AA, 1'b0, 1'b1, 1'b0);
    drive(o); handshake(o); in_valid = 1'b0;
    wait_drain();
    o = mk(16'h3001, 16'h0000, 1'b1, 1'b0, 1'b1);
    drive(o); handshake(o); in_valid = 1'b0;
    b = 0;
    while (!out_valid && b < 20) begin
      @(negedge clk);
      b++;
    end
    chk("ldb_valid", out_valid, 1'b1);
    chk("ldb_rdata", out_rdata, 16'hFF80);
    wait_drain();
    o = mk(16'h3000, 16'h1234, 1'b0, 1'b1, 1'b1);
    drive(o); handshake(o); in_valid = 1'b0;
    @(negedge clk);
    chk("stb_write", mem_write, 1'b1);
    chk("stb_wdata", mem_wdata, 16'h3434);
    chk("stb_byte_en", mem_byte_en, 2'b01);
    wait_drain();

    // Backpressure hold, then drain and accept on the same edge.
    ready_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ox = mk(16'hA5A5, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(ox); handshake(ox);
    oy = mk(16'h5A5A, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(oy);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_alu", out_alu, ox.alu);
      chk("bp_pc", out_pc, ox.pc);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    ready_force = 1'b1;
    handshake(oy);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", out_valid, 1'b1);
    chk("bp_next_alu", out_alu, 16'h5A5A);
    wait_drain();

    // Flush while empty blocks the offered instruction.
    o = mk(16'h0777, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(o);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_empty_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_empty_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Flush during BUSY: bus cycle completes, no result.
    fixed_delay = 2;
    o = mk(16'h3010, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(o); handshake(o); in_valid = 1'b0;
    void'(exp_q.pop_back());
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("kill_bus_held", mem_read, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("kill_no_valid", out_valid, 1'b0);
    end
    chk("kill_in_ready", in_ready, 1'b1);
    chk("kill_strobes", {mem_read, mem_write}, 2'b00);
    fixed_delay = -1;

    // Flush while FULL.
    ready_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    o = mk(16'h0123, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(o); handshake(o); in_valid = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("flush_full_held", out_valid, 1'b1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_full_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_full_valid", out_valid, 1'b0);
    ready_force = 1'b1;
    @(posedge clk);
    #1;

    // Timeout with a stalled memory, then asynchronous reset mid-transaction.
    chk("no_timeout_yet", timeout_err, 1'b0);
    mem_stall = 1'b1;
    o = mk(16'h3020, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(o); handshake(o); in_valid = 1'b0;
    void'(exp_q.pop_back());
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("to_err", timeout_err, (k >= 5) ? 1'b1 : 1'b0);
      chk("to_rd_held", mem_read, 1'b1);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_strobes", {mem_read, mem_write}, 2'b00);
    chk("arst_timeout", timeout_err, 1'b0);
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    mem_stall = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    o = mk(16'h0F0F, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(o); handshake(o); in_valid = 1'b0;
    wait_drain();
    chk("bus_queue_empty", bus_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
